// File: rtl/kbd_scan_decoder_pkg.sv
// Shared definitions for the PS/2 scan-code decoder slice.
//   state_t     : handshake FSM states (IDLE -> ACK -> PROC)
//   SC_EXT      : extended-key prefix byte
//   SC_BRK      : break (key release) prefix byte
//   SC_LSHIFT / SC_RSHIFT : left/right shift make codes
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    PROC
  } state_t;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

endpackage

// File: rtl/kbd_scan_decoder_if.sv
// Pop handshake between the PS/2 receiver FIFO and its consumer.
//   scan_code  : byte at the FIFO head, valid while ready=1
//   ready      : FIFO non-empty
//   nextdata_n : active-low pop strobe from the consumer
// master = receiver side, slave = decoder side.
interface kbd_scan_decoder_if;
  logic [7:0] scan_code;
  logic       ready;
  logic       nextdata_n;

  modport master (output scan_code, output ready, input nextdata_n);
  modport slave  (input scan_code, input ready, output nextdata_n);
endinterface

// File: rtl/kbd_ascii_rom.sv
// Combinational Set-2 scan code to ASCII table.
//   code  : scan code (make byte)
//   ext   : code was E0-prefixed; extended keys map to 0x00
//   shift : selects uppercase for letters
//   ascii : mapped character, 0x00 when unmapped
module kbd_ascii_rom (
  input  logic [7:0] code,
  input  logic       ext,
  input  logic       shift,
  output logic [7:0] ascii
);

  logic [7:0] lower;

  always_comb begin
    lower = '0;
    case (code)
      8'h1C: lower = "a";
      8'h32: lower = "b";
      8'h21: lower = "c";
      8'h23: lower = "d";
      8'h24: lower = "e";
      8'h2B: lower = "f";
      8'h34: lower = "g";
      8'h33: lower = "h";
      8'h43: lower = "i";
      8'h3B: lower = "j";
      8'h42: lower = "k";
      8'h4B: lower = "l";
      8'h3A: lower = "m";
      8'h31: lower = "n";
      8'h44: lower = "o";
      8'h4D: lower = "p";
      8'h15: lower = "q";
      8'h2D: lower = "r";
      8'h1B: lower = "s";
      8'h2C: lower = "t";
      8'h3C: lower = "u";
      8'h2A: lower = "v";
      8'h1D: lower = "w";
      8'h22: lower = "x";
      8'h35: lower = "y";
      8'h1A: lower = "z";
      default: lower = '0;
    endcase
  end

  always_comb begin
    ascii = '0;
    if (!ext) begin
      if (lower != '0) begin
        ascii = shift ? (lower - 8'h20) : lower;
      end else begin
        case (code)
          8'h45: ascii = "0";
          8'h16: ascii = "1";
          8'h1E: ascii = "2";
          8'h26: ascii = "3";
          8'h25: ascii = "4";
          8'h2E: ascii = "5";
          8'h36: ascii = "6";
          8'h3D: ascii = "7";
          8'h3E: ascii = "8";
          8'h46: ascii = "9";
          8'h29: ascii = 8'h20;
          8'h5A: ascii = 8'h0D;
          default: ascii = '0;
        endcase
      end
    end
  end

endmodule

// File: rtl/kbd_scan_decoder.sv
// Consumer stage for the PS/2 receiver FIFO: pops one byte per 3-cycle
// handshake, parses Set-2 make / F0 break / E0 extended sequences and
// tracks the held key, shift state and a key-press counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   fifo       : receiver handshake (scan_code, ready in; nextdata_n out)
//   key_valid  : a non-shift key is held
//   key_code   : code of the held / last-held key
//   key_ext    : held key was E0-prefixed
//   key_ascii  : registered, shift-adjusted ASCII of key_code
//   shift      : either shift key held
//   key_count  : distinct key presses since reset (wraps)
module kbd_scan_decoder
  import kbd_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  kbd_scan_decoder_if.slave fifo,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic [7:0]       key_ascii,
  output logic             shift,
  output logic [CNT_W-1:0] key_count
);

  state_t     state;
  logic [7:0] byte_r;
  logic       nextdata_r;
  logic       brk;
  logic       ext;
  logic       lshift;
  logic       rshift;
  logic       key_match;
  logic [7:0] rom_ascii;

  assign fifo.nextdata_n = nextdata_r;

  // Same physical key as the one currently held (code and E0 prefix).
  assign key_match = (byte_r == key_code) && (ext == key_ext);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_r     <= '0;
      nextdata_r <= 1'b1;
      brk        <= 1'b0;
      ext        <= 1'b0;
      lshift     <= 1'b0;
      rshift     <= 1'b0;
      shift      <= 1'b0;
      key_valid  <= 1'b0;
      key_code   <= '0;
      key_ext    <= 1'b0;
      key_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo.ready) begin
            byte_r     <= fifo.scan_code;
            nextdata_r <= 1'b0;
            state      <= ACK;
          end
        end
        ACK: begin
          nextdata_r <= 1'b1;
          state      <= PROC;
        end
        // The extra PROC cycle keeps ready/scan_code unsampled until the
        // receiver has advanced past the popped byte.
        PROC: begin
          state <= IDLE;
          if (byte_r == SC_EXT) begin
            ext <= 1'b1;
          end else if (byte_r == SC_BRK) begin
            brk <= 1'b1;
          end else if ((byte_r == SC_LSHIFT) || (byte_r == SC_RSHIFT)) begin
            if (byte_r == SC_LSHIFT) lshift <= ~brk;
            else                     rshift <= ~brk;
            // Registered shift reflects the post-update shift bits.
            shift <= ((byte_r == SC_LSHIFT) ? ~brk : lshift) |
                     ((byte_r == SC_RSHIFT) ? ~brk : rshift);
            brk <= 1'b0;
            ext <= 1'b0;
          end else if (brk) begin
            if (key_valid && key_match) key_valid <= 1'b0;
            brk <= 1'b0;
            ext <= 1'b0;
          end else begin
            // A matching make while held is typematic repeat: ignored.
            if (!(key_valid && key_match)) begin
              key_code  <= byte_r;
              key_ext   <= ext;
              key_valid <= 1'b1;
              key_count <= key_count + CNT_W'(1);
            end
            ext <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  kbd_ascii_rom u_rom (
    .code  (key_code),
    .ext   (key_ext),
    .shift (shift),
    .ascii (rom_ascii)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_ascii <= '0;
    else        key_ascii <= rom_ascii;
  end

endmodule

// File: tb/tb_kbd_scan_decoder.sv
module tb_kbd_scan_decoder;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             key_valid;
  logic [7:0]       key_code;
  logic             key_ext;
  logic [7:0]       key_ascii;
  logic             shift;
  logic [CNT_W-1:0] key_count;

  kbd_scan_decoder_if fifo ();

  kbd_scan_decoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo      (fifo),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_ascii (key_ascii),
    .shift     (shift),
    .key_count (key_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- receiver FIFO model ----------------
  logic [7:0] fifo_q[$];
  int pop_count = 0;
  int cyc = 0;
  int last_pop = 0;
  bit have_last = 0;

  initial begin
    fifo.ready = 1'b0;
    fifo.scan_code = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (fifo.nextdata_n === 1'b0) begin
        check("pop_nonempty", 32'(fifo_q.size() != 0), 1);
        if (have_last) check("pop_gap", 32'((cyc - last_pop) >= 3), 1);
        last_pop = cyc;
        have_last = 1;
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        pop_count++;
      end
      fifo.ready = (fifo_q.size() != 0);
      fifo.scan_code = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                   8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                   8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                   8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                  8'h3D, 8'h3E, 8'h46};

  bit         m_valid, m_kext, m_l, m_r, m_brk, m_ext;
  logic [7:0] m_code;
  int         m_count;

  function automatic logic [7:0] exp_ascii(input logic [7:0] c, input bit e, input bit s);
    if (e) return 8'h00;
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == c) return 8'((s ? 65 : 97) + i);
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == c) return 8'(48 + i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_kext = 0; m_l = 0; m_r = 0; m_brk = 0; m_ext = 0;
    m_code = 8'h00; m_count = 0;
  endtask

  task automatic model_apply(input logic [7:0] b);
    bit same;
    same = m_valid && (b == m_code) && (m_ext == m_kext);
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'h12 || b == 8'h59) begin
      if (b == 8'h12) m_l = !m_brk; else m_r = !m_brk;
      m_brk = 0; m_ext = 0;
    end else if (m_brk) begin
      if (same) m_valid = 0;
      m_brk = 0; m_ext = 0;
    end else begin
      if (!same) begin
        m_code = b; m_kext = m_ext; m_valid = 1;
        m_count = (m_count + 1) % (1 << CNT_W);
      end
      m_ext = 0;
    end
  endtask

  task automatic check_all(input string pfx);
    check({pfx, ".key_valid"}, 32'(key_valid), 32'(m_valid));
    check({pfx, ".key_code"}, 32'(key_code), 32'(m_code));
    check({pfx, ".key_ext"}, 32'(key_ext), 32'(m_kext));
    check({pfx, ".shift"}, 32'(shift), 32'(m_l | m_r));
    check({pfx, ".key_ascii"}, 32'(key_ascii), 32'(exp_ascii(m_code, m_kext, m_l | m_r)));
    check({pfx, ".key_count"}, 32'(key_count), 32'(m_count));
    check({pfx, ".nextdata_n"}, 32'(fifo.nextdata_n), 1);
  endtask

  // Queue bytes, wait (bounded) until all are popped, let outputs and
  // key_ascii settle, then compare against the model.
  task automatic send_bytes(input string pfx, input logic [7:0] bs[$]);
    int target;
    int budget;
    target = pop_count + bs.size();
    budget = bs.size() * 6 + 20;
    foreach (bs[i]) fifo_q.push_back(bs[i]);
    while (pop_count < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({pfx, ".pops"}, 32'(pop_count), 32'(target));
    repeat (4) @(negedge clk);
    foreach (bs[i]) model_apply(bs[i]);
    check_all(pfx);
  endtask

  task automatic send1(input string pfx, input logic [7:0] b);
    logic [7:0] one[$];
    one.push_back(b);
    send_bytes(pfx, one);
  endtask

  task automatic do_reset(input string pfx);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    check_all(pfx);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 9))
      0: return 8'hE0;
      1: return 8'hF0;
      2: return 8'h12;
      3: return 8'h59;
      4: return letter_codes[$urandom_range(0, 25)];
      5: return digit_codes[$urandom_range(0, 9)];
      6: return 8'h29;
      7: return 8'h5A;
      8: return 8'($urandom);
      default: return m_code;
    endcase
  endfunction

  logic [7:0] seq[$];

  initial begin
    int target;
    int budget;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single make
    send1("t1", 8'h1C);
    check("t1.ascii_a", 32'(key_ascii), 32'h61);
    check("t1.count", 32'(key_count), 1);

    // Shift, repeats, release
    do_reset("r2");
    seq = {8'h12, 8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12};
    target = pop_count + 8;
    foreach (seq[i]) begin
      send1("t2", seq[i]);
      if (i == 1) check("t2.ascii_A", 32'(key_ascii), 32'h41);
      if (i == 5) check("t2.released", 32'(key_valid), 0);
    end
    check("t2.count", 32'(key_count), 1);
    check("t2.shift_end", 32'(shift), 0);
    check("t2.pops8", 32'(pop_count), 32'(target));

    // Extended key
    do_reset("r3");
    seq = {8'hE0, 8'h75, 8'hF0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    foreach (seq[i]) begin
      send1("t3", seq[i]);
      if (i == 1) begin
        check("t3.ext", 32'(key_ext), 1);
        check("t3.code", 32'(key_code), 32'h75);
        check("t3.ascii0", 32'(key_ascii), 0);
      end
      if (i == 3) check("t3.nonext_keep", 32'(key_valid), 1);
    end
    check("t3.ext_release", 32'(key_valid), 0);

    // Replacement without release
    do_reset("r4");
    send1("t4", 8'h16);
    send1("t4", 8'h1E);
    check("t4.code", 32'(key_code), 32'h1E);
    check("t4.ascii", 32'(key_ascii), 32'h32);
    check("t4.count", 32'(key_count), 2);

    // Counter wrap with back-to-back bytes
    do_reset("r5");
    seq.delete();
    for (int i = 0; i < 256; i++) begin
      seq.push_back(8'h29);
      seq.push_back(8'hF0);
      seq.push_back(8'h29);
    end
    send_bytes("t5", seq);
    check("t5.wrap", 32'(key_count), 0);

    // Reset during ACK after F0
    do_reset("r6");
    target = pop_count + 1;
    budget = 20;
    fifo_q.push_back(8'hF0);
    while (pop_count < target && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    check("t6.f0_popped", 32'(pop_count), 32'(target));
    check("t6.in_ack", 32'(fifo.nextdata_n), 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6.async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send1("t6.make", 8'h1C);
    check("t6.valid", 32'(key_valid), 1);

    // Randomized single bytes then bursts
    do_reset("r7");
    for (int i = 0; i < 250; i++) begin
      send1("rnd", rand_byte());
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    for (int i = 0; i < 30; i++) begin
      seq.delete();
      for (int j = 0; j < int'($urandom_range(2, 8)); j++) seq.push_back(rand_byte());
      send_bytes("burst", seq);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/kbd_scan_decoder.md
# kbd_scan_decoder

Consumer stage for the PS/2 receiver FIFO. Pops scan-code bytes through the receiver's `ready`/`nextdata_n` handshake, parses Set-2 make, break (`F0`) and extended (`E0`) sequences, and tracks the currently held key, shift state and a key-press counter. Provides the held key's raw code and ASCII value to display and seven-segment logic. One byte is consumed per 3-cycle handshake.

## Interface
Parameters:
- `CNT_W`, 8: width of the key-press counter.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `scan_code`  in  8  byte at the head of the receiver FIFO; valid while `ready`=1.
- `ready`  in  1  receiver FIFO non-empty.
- `nextdata_n`  out  1  registered, active-low pop strobe to the receiver; low for exactly one cycle per byte.
- `key_valid`  out  1  a non-shift key is currently held.
- `key_code`  out  8  scan code of the held or last-held key.
- `key_ext`  out  1  held key was `E0`-prefixed.
- `key_ascii`  out  8  ASCII of `key_code`, shift-adjusted; `0x00` if unmapped or `key_ext`=1.
- `shift`  out  1  left shift (`0x12`) or right shift (`0x59`) is held.
- `key_count`  out  CNT_W  number of distinct key presses since reset.

## Operation
- Reset values: `nextdata_n`=1, `key_valid`=0, `key_code`=0, `key_ext`=0, `key_ascii`=0, `shift`=0, `key_count`=0. Internal `brk`/`ext` flags and both shift bits are 0. FSM is in IDLE.
- FSM:
  - IDLE: if `ready`=1, capture `scan_code` into `byte_r`, drive `nextdata_n`<=0, go to ACK. Otherwise stay.
  - ACK: drive `nextdata_n`<=1, go to PROC.
  - PROC: decode `byte_r` (rules below), go to IDLE.
- PROC exists so that `ready` and `scan_code` are not sampled until the receiver has advanced its read pointer.
- Decode rules, applied in PROC:
  - `E0`: set `ext`.
  - `F0`: set `brk`.
  - `0x12`/`0x59`: set the matching shift bit, or clear it if `brk`=1. Clear `brk` and `ext`. Do not touch the key outputs or `key_count`.
  - Any other byte with `brk`=1 (release): if `key_valid`=1, byte equals `key_code`, and `ext` equals `key_ext`, clear `key_valid`. Otherwise ignore. Clear `brk` and `ext`.
  - Any other byte with `brk`=0 (make):
    - If `key_valid`=1 and byte/`ext` match the held key, this is typematic repeat: no change.
    - Otherwise set `key_code`=byte, `key_ext`=`ext`, `key_valid`=1, and increment `key_count`, wrapping from all-ones to 0.
    - Clear `ext`.
- A new make while another key is held replaces the held key and counts.
- `key_ascii` is a registered lookup of the final `key_code`/`key_ext`/`shift`, updated one cycle after any of them changes.
- ASCII map:
  - Letters: lowercase when `shift`=0, uppercase when `shift`=1.
  - Digits `0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46` map to '0'..'9' regardless of shift.
  - Space `0x29` maps to `0x20`. Enter `0x5A` maps to `0x0D`.
  - Everything else maps to `0x00`.

## Timing
- `ready` rises in cycle t (FSM in IDLE): `nextdata_n` is low in cycle t+1 and high in cycle t+2. Decoded outputs change in cycle t+3. `key_ascii` settles in cycle t+4.
- Earliest next capture is cycle t+3. Sustained throughput is 1 byte per 3 cycles.
- `ready` dropping during ACK or PROC has no effect. No pop is issued while `ready`=0.
- Reset asserted mid-sequence returns all state to reset values immediately, including `nextdata_n`=1. No partial `E0`/`F0` prefix survives reset.
- `key_count` wraps modulo 2^CNT_W with no saturation and no flag.

## Structure
- Shared package `kbd_pkg` contains:
  - FSM state enum (IDLE/ACK/PROC).
  - Prefix constants `SC_EXT`=`0xE0` and `SC_BRK`=`0xF0`.
  - Shift codes `SC_LSHIFT`=`0x12` and `SC_RSHIFT`=`0x59`.
- Sub-module `kbd_ascii_rom` is a combinational scan-code-to-ASCII table with inputs code, ext and shift.
- The parent registers the ROM output into `key_ascii`.

## Test plan
- Byte `1C` alone, `ready` held until popped: one `nextdata_n` low pulse; `key_valid`=1, `key_code`=`0x1C`, `key_ascii`=`0x61`, `key_count`=1.
- Sequence `12 1C 1C 1C F0 1C F0 12`:
  - `key_ascii`=`0x41` while shift is held.
  - `key_count`=1; repeats do not count.
  - `key_valid`=0 after `F0 1C`.
  - `shift`=0 at the end.
  - Exactly 8 pops.
- Sequence `E0 75 F0 75 E0 F0 75`:
  - `key_ext`=1, `key_code`=`0x75`, `key_ascii`=0 after `E0 75`.
  - Non-extended `F0 75` leaves `key_valid`=1.
  - `E0 F0 75` clears `key_valid`.
- `16` then `1E` without a release: `key_code`=`0x1E`, `key_ascii`=`0x32`, `key_count`=2.
- 256 distinct make/break pairs of `0x29`: `key_count` wraps to 0. Spacing between pops is never less than 3 cycles.
- Assert `rst_n` low in the ACK cycle after `F0`:
  - All outputs take reset values asynchronously.
  - The next byte `1C` is treated as a make, not a release.
